slave_responder: RTL and testbench

- Slave-side end of the system bus: receives the per-slave wen/ren strobe produced by the bus address decoder, plus the shared address and write-data lines.
- Performs one access at a time on a local synchronous memory port.
- Returns read data to the bus read mux with a one-cycle rvalid pulse.
- Exposes ready so the master knows when the slave accepts a new request.

---
 rtl/slave_responder_pkg.sv | 16 +
 rtl/slave_responder.sv | 116 +++++++++++
 tb/tb_slave_responder.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/slave_responder_pkg.sv
// Shared bus definitions used by the slave responder, address decoder and read mux.
package slave_responder_pkg;

    localparam int unsigned BUS_ADDR_WIDTH       = 16;
    localparam int unsigned BUS_DEVICE_BIT_WIDTH = 2;
    localparam int unsigned BUS_DATA_WIDTH       = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

endpackage

// File: rtl/slave_responder.sv
// Slave-side bus endpoint: accepts one decoded read/write strobe at a time and
// runs it against a local synchronous memory port with fixed read latency.
module slave_responder
    import slave_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH       = BUS_ADDR_WIDTH,
    parameter int unsigned DEVICE_BIT_WIDTH = BUS_DEVICE_BIT_WIDTH,
    parameter int unsigned DATA_WIDTH       = BUS_DATA_WIDTH,
    parameter int unsigned READ_LATENCY     = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [ADDR_WIDTH-1:0]                  addr,
    input  logic [DATA_WIDTH-1:0]                  wdata,
    input  logic                                   wen,
    input  logic                                   ren,
    output logic                                   ready,
    output logic [DATA_WIDTH-1:0]                  rdata,
    output logic                                   rvalid,
    output logic                                   wack,
    output logic                                   err,
    output logic [ADDR_WIDTH-DEVICE_BIT_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]                  mem_wdata,
    output logic                                   mem_we,
    output logic                                   mem_re,
    input  logic [DATA_WIDTH-1:0]                  mem_rdata
);

    localparam int unsigned OFF_W = ADDR_WIDTH - DEVICE_BIT_WIDTH;
    localparam int unsigned CNT_W = $clog2(READ_LATENCY + 1);

    state_e           state_q, state_d;
    logic [OFF_W-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q;

    // Device-select bits belong to the decoder; reduced here only to mark them consumed.
    logic unused_dev_bits;
    assign unused_dev_bits = ^addr[ADDR_WIDTH-1:OFF_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Latency counter: loaded in READ, checked for zero before each decrement in WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state_q == ST_READ) begin
            cnt_q <= CNT_W'(READ_LATENCY - 1);
        end else if (state_q == ST_WAIT && cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (wen || ren) begin
                    addr_d  = addr[OFF_W-1:0];
                    wdata_d = wdata;
                    // A colliding read is dropped; the write proceeds and err flags it.
                    if (wen) begin
                        state_d = ST_WRITE;
                        err_d   = ren;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            ST_READ:  state_d = ST_WAIT;
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    rdata_d = mem_rdata;
                    state_d = ST_RESP;
                end
            end
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ready     = (state_q == ST_IDLE);
        mem_we    = (state_q == ST_WRITE);
        wack      = (state_q == ST_WRITE);
        mem_re    = (state_q == ST_READ);
        rvalid    = (state_q == ST_RESP);
        err       = err_q;
        rdata     = rdata_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
    end

endmodule

// File: tb/tb_slave_responder.sv
// Scoreboard bench: two responders (read latency 2 and 1) against behavioural memories.
module tb_slave_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst_s, wen_s, ren_s;
    logic [15:0] addr_s [2];
    logic [7:0]  wdata_s [2];

    logic [1:0]  ready_w, rvalid_w, wack_w, err_w, mem_we_w, mem_re_w;
    logic [7:0]  rdata_w [2];
    logic [7:0]  mem_wdata_w [2];
    logic [7:0]  mem_rdata_w [2];
    logic [13:0] mem_addr_w [2];

    slave_responder #(
        .ADDR_WIDTH(16), .DEVICE_BIT_WIDTH(2), .DATA_WIDTH(8), .READ_LATENCY(2)
    ) u_dut_l2 (
        .clk(clk), .rst(rst_s[0]), .addr(addr_s[0]), .wdata(wdata_s[0]),
        .wen(wen_s[0]), .ren(ren_s[0]), .ready(ready_w[0]), .rdata(rdata_w[0]),
        .rvalid(rvalid_w[0]), .wack(wack_w[0]), .err(err_w[0]),
        .mem_addr(mem_addr_w[0]), .mem_wdata(mem_wdata_w[0]),
        .mem_we(mem_we_w[0]), .mem_re(mem_re_w[0]), .mem_rdata(mem_rdata_w[0])
    );

    slave_responder #(
        .ADDR_WIDTH(16), .DEVICE_BIT_WIDTH(2), .DATA_WIDTH(8), .READ_LATENCY(1)
    ) u_dut_l1 (
        .clk(clk), .rst(rst_s[1]), .addr(addr_s[1]), .wdata(wdata_s[1]),
        .wen(wen_s[1]), .ren(ren_s[1]), .ready(ready_w[1]), .rdata(rdata_w[1]),
        .rvalid(rvalid_w[1]), .wack(wack_w[1]), .err(err_w[1]),
        .mem_addr(mem_addr_w[1]), .mem_wdata(mem_wdata_w[1]),
        .mem_we(mem_we_w[1]), .mem_re(mem_re_w[1]), .mem_rdata(mem_rdata_w[1])
    );

    // Memories: data shows up READ_LATENCY cycles after mem_re, 0xEE otherwise.
    logic [7:0] mem0 [16384];
    logic [7:0] mem1 [16384];
    logic [7:0] pipe0_a, pipe0_b, pipe1_a;

    always @(posedge clk) begin
        if (mem_we_w[0]) mem0[mem_addr_w[0]] <= mem_wdata_w[0];
        if (mem_we_w[1]) mem1[mem_addr_w[1]] <= mem_wdata_w[1];
        pipe0_a <= mem_re_w[0] ? mem0[mem_addr_w[0]] : 8'hEE;
        pipe0_b <= pipe0_a;
        pipe1_a <= mem_re_w[1] ? mem1[mem_addr_w[1]] : 8'hEE;
    end
    assign mem_rdata_w[0] = pipe0_b;
    assign mem_rdata_w[1] = pipe1_a;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned dut;
        int unsigned cyc;
        logic [13:0] a;
        logic [7:0]  d;
    } ev_t;

    ev_t q_wr[$];
    ev_t q_rd[$];
    ev_t q_rv[$];
    ev_t q_er[$];

    int unsigned n_chk = 0;
    int unsigned n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name, input int unsigned d);
        n_chk++;
        n_fail++;
        $display("FAIL %s: asserted on dut%0d at cycle %0d, required no event", name, d, cyc);
    endtask

    always @(negedge clk) begin
        ev_t e;
        for (int d = 0; d < 2; d++) begin
            if (err_w[d]) begin
                if (q_er.size() == 0) unexpected("err", d);
                else begin
                    e = q_er.pop_front();
                    chk("err_dut", d, e.dut);
                    chk("err_cycle", cyc, e.cyc);
                end
            end
            if (wack_w[d] || mem_we_w[d]) begin
                if (q_wr.size() == 0) unexpected("mem_we/wack", d);
                else begin
                    e = q_wr.pop_front();
                    chk("wack_with_we", wack_w[d], mem_we_w[d]);
                    chk("wr_dut", d, e.dut);
                    chk("wr_cycle", cyc, e.cyc);
                    chk("wr_mem_addr", mem_addr_w[d], e.a);
                    chk("wr_mem_wdata", mem_wdata_w[d], e.d);
                end
            end
            if (mem_re_w[d]) begin
                if (q_rd.size() == 0) unexpected("mem_re", d);
                else begin
                    e = q_rd.pop_front();
                    chk("rd_dut", d, e.dut);
                    chk("rd_cycle", cyc, e.cyc);
                    chk("rd_mem_addr", mem_addr_w[d], e.a);
                end
            end
            if (rvalid_w[d]) begin
                if (q_rv.size() == 0) unexpected("rvalid", d);
                else begin
                    e = q_rv.pop_front();
                    chk("rv_dut", d, e.dut);
                    chk("rv_cycle", cyc, e.cyc);
                    chk("rv_rdata", rdata_w[d], e.d);
                end
            end
        end
    end

    // Drives one strobe cycle at the current negedge; returns at the next negedge.
    task automatic issue(input int unsigned d, input logic w, input logic r,
                         input logic [15:0] a, input logic [7:0] wd,
                         input logic [13:0] off, input logic [7:0] rd_exp,
                         input bit accept, input bit resp, output int unsigned n);
        ev_t e;
        n = cyc;
        addr_s[d]  = a;
        wdata_s[d] = wd;
        wen_s[d]   = w;
        ren_s[d]   = r;
        if (accept) begin
            e.dut = d;
            e.a   = off;
            e.cyc = n + 1;
            e.d   = wd;
            if (w) begin
                q_wr.push_back(e);
                if (r) q_er.push_back(e);
            end else if (r) begin
                q_rd.push_back(e);
                if (resp) begin
                    e.cyc = n + 2 + ((d == 0) ? 2 : 1);
                    e.d   = rd_exp;
                    q_rv.push_back(e);
                end
            end
        end
        @(negedge clk);
        wen_s[d] = 1'b0;
        ren_s[d] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        rst_s = '1;
        wen_s = '0;
        ren_s = '0;
        for (int d = 0; d < 2; d++) begin
            addr_s[d]  = '0;
            wdata_s[d] = '0;
        end
        repeat (3) @(negedge clk);
        rst_s = '0;
        @(negedge clk);

        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", ready_w[d], 1);
            chk("rst_rvalid", rvalid_w[d], 0);
            chk("rst_wack", wack_w[d], 0);
            chk("rst_err", err_w[d], 0);
            chk("rst_mem_we", mem_we_w[d], 0);
            chk("rst_mem_re", mem_re_w[d], 0);
            chk("rst_rdata", rdata_w[d], 0);
            chk("rst_mem_addr", mem_addr_w[d], 0);
            chk("rst_mem_wdata", mem_wdata_w[d], 0);
        end

        // Plain write
        issue(0, 1, 0, 16'h4123, 8'hA5, 14'h0123, 8'h00, 1, 1, n);
        chk("wr_ready_busy", ready_w[0], 0);
        @(negedge clk);
        chk("wr_ready_back", ready_w[0], 1);

        // Seed offset 0x0010 through a different device-select pattern
        issue(0, 1, 0, 16'hC010, 8'h3C, 14'h0010, 8'h00, 1, 1, n);
        @(negedge clk);

        // Read, latency 2
        issue(0, 0, 1, 16'h8010, 8'h00, 14'h0010, 8'h3C, 1, 1, n);
        chk("rd_ready_busy", ready_w[0], 0);
        repeat (3) @(negedge clk);
        chk("rd_ready_resp", ready_w[0], 0);
        chk("rd_rdata_resp", rdata_w[0], 8'h3C);
        @(negedge clk);
        chk("rd_ready_back", ready_w[0], 1);
        repeat (3) @(negedge clk);
        chk("rd_rdata_hold", rdata_w[0], 8'h3C);
        chk("rd_rvalid_low", rvalid_w[0], 0);

        // Simultaneous strobes: write wins, err pulses
        issue(0, 1, 1, 16'h4055, 8'h77, 14'h0055, 8'h00, 1, 1, n);
        @(negedge clk);
        chk("sim_ready_back", ready_w[0], 1);
        repeat (6) @(negedge clk);

        // Writes while busy must be ignored
        issue(0, 0, 1, 16'h8010, 8'h00, 14'h0010, 8'h3C, 1, 1, n);
        issue(0, 1, 0, 16'h4200, 8'h99, 14'h0200, 8'h00, 0, 0, n);
        issue(0, 1, 0, 16'h4201, 8'h9A, 14'h0201, 8'h00, 0, 0, n);
        repeat (6) @(negedge clk);

        // Reset in the middle of a read
        issue(0, 0, 1, 16'h8010, 8'h00, 14'h0010, 8'h00, 1, 0, n);
        @(negedge clk);
        rst_s[0] = 1'b1;
        @(negedge clk);
        rst_s[0] = 1'b0;
        chk("mid_rst_ready", ready_w[0], 1);
        chk("mid_rst_rdata", rdata_w[0], 0);
        chk("mid_rst_mem_re", mem_re_w[0], 0);
        chk("mid_rst_rvalid", rvalid_w[0], 0);
        chk("mid_rst_mem_addr", mem_addr_w[0], 0);
        repeat (6) @(negedge clk);

        // Offset all-ones, latency 1
        issue(1, 1, 0, 16'hFFFF, 8'hFF, 14'h3FFF, 8'h00, 1, 1, n);
        @(negedge clk);
        chk("bnd_wr_ready_back", ready_w[1], 1);
        issue(1, 0, 1, 16'hFFFF, 8'h00, 14'h3FFF, 8'hFF, 1, 1, n);
        chk("bnd_rd_ready_busy", ready_w[1], 0);
        @(negedge clk);
        chk("bnd_rd_ready_wait", ready_w[1], 0);
        @(negedge clk);
        chk("bnd_rd_rdata", rdata_w[1], 8'hFF);
        @(negedge clk);
        chk("bnd_rd_ready_back", ready_w[1], 1);

        // Offset zero, latency 1
        issue(1, 1, 0, 16'h8000, 8'h5A, 14'h0000, 8'h00, 1, 1, n);
        @(negedge clk);
        issue(1, 0, 1, 16'h4000, 8'h00, 14'h0000, 8'h5A, 1, 1, n);
        repeat (5) @(negedge clk);
        chk("bnd_rdata_hold", rdata_w[1], 8'h5A);

        chk("pending_events", q_wr.size() + q_rd.size() + q_rv.size() + q_er.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
